// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS datapath: stage enables/flushes for load-use,
// taken-branch and data-memory freeze, plus a wait timeout and saturating profiling counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W        = 32,
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic             ex_mem_branch,
    input  logic             ex_mem_zero,
    input  logic             ex_mem_mem_read,
    input  logic             ex_mem_mem_write,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pc_src,
    output logic             dmem_req,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] wait_count
);
    // Memory handshake: dmem_req is held for as long as EX/MEM holds an access; the
    // access completes on the cycle dmem_ready=1, and until then the whole pipe freezes.
    typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;
    localparam int TMR_W = $clog2(WAIT_TIMEOUT + 1);

    state_t           state;
    logic [TMR_W-1:0] wait_tmr;
    logic             mem_acc, freeze, taken, lu, sel_taken, sel_lu;

    always_comb begin
        mem_acc   = ex_mem_mem_read | ex_mem_mem_write;
        freeze    = mem_acc & ~dmem_ready;
        taken     = ex_mem_branch & ex_mem_zero;
        lu        = id_ex_mem_read & (id_ex_rt != 5'd0) &
                    ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt)));
        sel_taken = ~rst & ~freeze & taken;
        sel_lu    = ~rst & ~freeze & ~taken & lu;
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_src       = 1'b0;
        dmem_req     = mem_acc & ~rst;
        if (rst || freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = rst;
            id_ex_flush  = rst;
            ex_mem_flush = rst;
        end else if (taken) begin
            // A taken branch squashes the three younger instructions; lu is moot.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            pc_src       = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_tmr    <= '0;
            mem_error   <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
            wait_count  <= '0;
        end else begin
            case (state)
                RUN:  if (freeze)  state <= WAIT;
                WAIT: if (!freeze) state <= RUN;
                default:           state <= RUN;
            endcase
            // The timer counts every frozen cycle, including the one that enters WAIT.
            if (freeze) begin
                if (wait_tmr != TMR_W'(WAIT_TIMEOUT))
                    wait_tmr <= wait_tmr + 1'b1;
                if (wait_tmr == TMR_W'(WAIT_TIMEOUT - 1))
                    mem_error <= 1'b1;
            end else begin
                wait_tmr <= '0;
            end
            if (sel_lu && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (sel_taken && flush_count != '1)
                flush_count <= flush_count + 1'b1;
            if (freeze && wait_count != '1)
                wait_count <= wait_count + 1'b1;
        end
    end
endmodule
